tx_frame_arbiter: RTL and testbench
===================================

Name: tx_frame_arbiter

Overview:
Frame-granular arbiter sharing the single RMII transmit datapath (AXIS byte stream into the packet transmitter) between NUM_SRC frame producers, e.g. DCT result packets and ARP/echo replies. Grants one source per frame and never interleaves bytes of different frames. Enforces a minimum idle gap between frames. Truncates runaway frames at MAX_FRAME_BYTES.

Parameters:
DATA_WIDTH, 8, AXIS byte width.
NUM_SRC, 2, number of requesting sources, legal range 2..8.
GAP_CYCLES, 12, forced idle clocks after each frame's final beat; 0 is legal and means no gap.
MAX_FRAME_BYTES, 1514, max beats per frame (header + payload, FCS excluded).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tlast  in  NUM_SRC  per-source end of frame
s_axis_tready  out  NUM_SRC  per-source ready
m_axis_tdata  out  DATA_WIDTH  to transmitter
m_axis_tvalid  out  1  to transmitter
m_axis_tlast  out  1  to transmitter
m_axis_tready  in  1  from transmitter
grant  out  NUM_SRC  one-hot current owner, 0 when none
busy  out  1  high in any state except IDLE
trunc_err  out  1  one-cycle pulse on a forced truncation
err_src  out  clog2(NUM_SRC)  index of the last truncated source, held until the next truncation

Behaviour:
- Reset values: state IDLE, grant 0, busy 0, trunc_err 0, err_src 0, all s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0.
- Reset sets the round-robin pointer so that source 0 has first priority.
- Reset mid-frame aborts immediately. No tlast is emitted. The downstream transmitter is reset by the same rst.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE:
  - If any s_axis_tvalid is high, pick a winner and register grant.
  - Round-robin search starts at last_owner+1 and wraps modulo NUM_SRC.
  - Next state is XFER. Latency from tvalid sampled to grant asserted is 1 clk.
  - The first beat can transfer in that same XFER cycle.
- XFER:
  - m_axis_* is a combinational mux of the granted source.
  - s_axis_tready[g] = m_axis_tready; all other readies are 0.
  - The beat counter (11+ bits) increments on each m handshake.
  - Handshake with tlast: go to GAP, load the gap counter, update last_owner.
  - Granted source dropping tvalid mid-frame: grant holds and no re-arbitration happens; m_axis_tvalid follows the source.
  - m_axis_tready low: hold; data stability is the source's responsibility.
- Truncation: on the handshake of beat number MAX_FRAME_BYTES with source tlast=0:
  - Force m_axis_tlast=1 on that beat.
  - Pulse trunc_err and set err_src.
  - Go to DRAIN.
  - If source tlast=1 on exactly that beat, the frame is normal: no error, go to GAP.
- DRAIN: s_axis_tready[g]=1, m_axis_tvalid=0. Discard source beats until a tlast handshake, then go to GAP.
- GAP: all readies 0, m_axis_tvalid 0. Count GAP_CYCLES clocks, then go to IDLE. With GAP_CYCLES=0, go from XFER/DRAIN directly to IDLE.
- Minimum spacing between the last beat of frame N and the first beat of frame N+1: GAP_CYCLES+2 clocks (the gap, plus the IDLE arbitration cycle, plus the first XFER cycle).
- A source asserting tvalid while not granted is simply stalled; it is never dropped.
- last_owner updates only on frame completion, including truncated frames.

Optional Feature:
TX_ARB_PRIO_EN
- Defined: strict priority. The lowest-index requesting source always wins in IDLE, and the round-robin pointer is unused.
- Undefined: round-robin as described.
- Frame atomicity, gap and truncation rules are identical in both cases.

Test Plan:
1. Src0 sends a 64-byte frame, m_axis_tready=1 throughout -> grant=01 one clk after tvalid; 64 beats out with tlast on beat 64; busy high; tready low for GAP_CYCLES=12 clks; then IDLE.
2. Src0 and src1 request continuously with 60-byte frames (round-robin build) -> order 0,1,0,1; no byte interleave; 14 clks from each tlast to the next frame's first beat.
3. Same stimulus as 2 with TX_ARB_PRIO_EN defined -> src0 wins every arbitration; src1 is never granted while src0 keeps tvalid high in IDLE.
4. MAX_FRAME_BYTES=16, src1 sends 20 beats -> m sees 16 beats with tlast on beat 16; trunc_err pulses 1 clk; err_src=1; beats 17-20 accepted and discarded; then GAP.
5. Random m_axis_tready (50%) and source tvalid bubbles on a 100-byte frame -> byte sequence out matches the source exactly; grant never changes mid-frame; tready asserted only to the owner.
6. Assert rst at beat 30 of a frame -> next clk all outputs at reset values; after rst releases, a pending src1 request is granted only after src0 has had first priority if it is also requesting.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: frame-granular arbiter sharing one AXIS byte stream toward the RMII transmitter.
// Defining TX_ARB_PRIO_EN selects strict lowest-index priority instead of round-robin.
module tx_frame_arbiter #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_SRC         = 2,
  parameter int GAP_CYCLES      = 12,
  parameter int MAX_FRAME_BYTES = 1514,
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy,
  output logic                          trunc_err,
  output logic [IW-1:0]                 err_src
);

  localparam int BW = ($clog2(MAX_FRAME_BYTES + 1) > 11) ? $clog2(MAX_FRAME_BYTES + 1) : 11;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]      GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : {GW{1'b0}};
  localparam logic [BW-1:0]      BEAT_LAST = BW'(MAX_FRAME_BYTES - 1);
  localparam logic [IW-1:0]      SRC_LAST  = IW'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] SRC_ONE   = {{(NUM_SRC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [NUM_SRC-1:0]    grant_r, grant_s;
  logic [IW-1:0]         owner_r, owner_s;
  logic [IW-1:0]         last_owner_r, last_owner_s;
  logic [IW-1:0]         err_src_r, err_src_s;
  logic [IW-1:0]         winner_s;
  logic                  win_found_s;
  logic [BW-1:0]         beat_cnt_r, beat_cnt_s;
  logic [GW-1:0]         gap_cnt_r, gap_cnt_s;
  logic                  trunc_err_r, trunc_err_s;
  logic [DATA_WIDTH-1:0] own_data_s;
  logic                  own_valid_s;
  logic                  own_last_s;
  logic                  m_hs_s;
  logic                  at_max_s;

  // Source currently holding the frame, selected by the registered owner index.
  always_comb begin
    own_data_s  = s_axis_tdata[int'(owner_r) * DATA_WIDTH +: DATA_WIDTH];
    own_valid_s = s_axis_tvalid[owner_r];
    own_last_s  = s_axis_tlast[owner_r];
  end

  // Winner selection for the next frame.
  always_comb begin
    int  idx;
    logic take;
    winner_s    = {IW{1'b0}};
    win_found_s = 1'b0;
    idx         = 0;
    take        = 1'b0;
`ifdef TX_ARB_PRIO_EN
    // Descending scan so the lowest-index requester is the last to overwrite.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      take        = s_axis_tvalid[i];
      winner_s    = take ? IW'(i) : winner_s;
      win_found_s = win_found_s | take;
    end
`else
    // Search begins just after the previous owner and wraps.
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx         = int'(last_owner_r) + i;
      idx         = (idx >= NUM_SRC) ? idx - NUM_SRC : idx;
      take        = !win_found_s && s_axis_tvalid[idx];
      winner_s    = take ? IW'(idx) : winner_s;
      win_found_s = win_found_s | take;
    end
`endif
  end

  // Next-state, datapath steering and register updates.
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    owner_s       = owner_r;
    last_owner_s  = last_owner_r;
    beat_cnt_s    = beat_cnt_r;
    gap_cnt_s     = gap_cnt_r;
    trunc_err_s   = 1'b0;
    err_src_s     = err_src_r;
    m_axis_tdata  = {DATA_WIDTH{1'b0}};
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = {NUM_SRC{1'b0}};
    at_max_s      = (beat_cnt_r == BEAT_LAST);
    m_hs_s        = 1'b0;

    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_s    = XFER;
          owner_s    = winner_s;
          grant_s    = SRC_ONE << winner_s;
          beat_cnt_s = {BW{1'b0}};
        end else begin
          grant_s    = {NUM_SRC{1'b0}};
        end
      end

      XFER: begin
        m_axis_tdata  = own_data_s;
        m_axis_tvalid = own_valid_s;
        m_axis_tlast  = own_last_s | at_max_s;
        s_axis_tready = {{(NUM_SRC-1){1'b0}}, m_axis_tready} << owner_r;
        m_hs_s        = own_valid_s & m_axis_tready;
        if (m_hs_s && own_last_s) begin
          state_s      = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_cnt_s    = GAP_LOAD;
          last_owner_s = owner_r;
          grant_s      = {NUM_SRC{1'b0}};
        end else if (m_hs_s && at_max_s) begin
          // Runaway frame: the forced tlast already went out on this beat.
          state_s     = DRAIN;
          trunc_err_s = 1'b1;
          err_src_s   = owner_r;
        end else if (m_hs_s) begin
          beat_cnt_s  = beat_cnt_r + BW'(1);
        end else begin
          beat_cnt_s  = beat_cnt_r;
        end
      end

      DRAIN: begin
        s_axis_tready = SRC_ONE << owner_r;
        if (own_valid_s && own_last_s) begin
          state_s      = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_cnt_s    = GAP_LOAD;
          last_owner_s = owner_r;
          grant_s      = {NUM_SRC{1'b0}};
        end else begin
          state_s      = DRAIN;
        end
      end

      GAP: begin
        if (gap_cnt_r == {GW{1'b0}}) begin
          state_s   = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r - GW'(1);
        end
      end

      default: begin
        state_s = IDLE;
        grant_s = {NUM_SRC{1'b0}};
      end
    endcase
  end

  // State and registered status; reset leaves source 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= {NUM_SRC{1'b0}};
      owner_r      <= {IW{1'b0}};
      last_owner_r <= SRC_LAST;
      beat_cnt_r   <= {BW{1'b0}};
      gap_cnt_r    <= {GW{1'b0}};
      trunc_err_r  <= 1'b0;
      err_src_r    <= {IW{1'b0}};
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      owner_r      <= owner_s;
      last_owner_r <= last_owner_s;
      beat_cnt_r   <= beat_cnt_s;
      gap_cnt_r    <= gap_cnt_s;
      trunc_err_r  <= trunc_err_s;
      err_src_r    <= err_src_s;
    end
  end

  assign grant     = grant_r;
  assign busy      = (state_r != IDLE);
  assign trunc_err = trunc_err_r;
  assign err_src   = err_src_r;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: drivers push expected beats, a negedge monitor pops and compares.
module tb_tx_frame_arbiter;

  localparam int GAP  = 12;
  localparam int MAXB = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_axis_tdata;
  logic [1:0]  s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]  grant;
  logic        busy, trunc_err;
  logic        err_src;

  logic [7:0]  src_data [2];
  logic [1:0]  src_valid, src_last;

  int checks = 0, errors = 0;
  int cyc = 0;
  int trunc_cnt = 0;
  bit mon_en = 1'b1, rnd_en = 1'b0, gap_chk_en = 1'b0;
  bit in_frame = 1'b0, have_last = 1'b0;
  int cur_src = 0, last_cyc = 0;
  int order_q[$];
  logic [8:0] exp0_q[$], exp1_q[$];

  assign s_axis_tdata  = {src_data[1], src_data[0]};
  assign s_axis_tvalid = src_valid;
  assign s_axis_tlast  = src_last;

  tx_frame_arbiter #(
    .DATA_WIDTH(8), .NUM_SRC(2), .GAP_CYCLES(GAP), .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .grant(grant), .busy(busy), .trunc_err(trunc_err), .err_src(err_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Wait for the handshake of source s on the coming edge; returns just after that edge.
  task automatic wait_hs(input int s);
    int  n = 0;
    bit  done = 1'b0;
    while (!done) begin
      @(negedge clk);
      done = s_axis_tready[s];
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 400) begin
        fail_now("handshake_timeout");
        done = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input int s, input int len, input int fr, input bit bubble);
    for (int b = 0; b < len; b++) begin
      if (bubble && $urandom_range(0, 2) == 0) begin
        src_valid[s] = 1'b0;
        @(posedge clk);
        #1;
      end
      src_data[s]  = 8'(s * 100 + fr * 13 + b * 7);
      src_last[s]  = (b == len - 1);
      src_valid[s] = 1'b1;
      if (b < MAXB) begin
        if (s == 0) exp0_q.push_back({(b == len - 1) || (b == MAXB - 1), src_data[s]});
        else        exp1_q.push_back({(b == len - 1) || (b == MAXB - 1), src_data[s]});
      end
      wait_hs(s);
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || in_frame) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("idle_timeout");
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard monitor.
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (!rst && mon_en && m_axis_tvalid && m_axis_tready) begin
      if (!in_frame) begin
        if (order_q.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          cur_src  = order_q.pop_front();
          in_frame = 1'b1;
          if (gap_chk_en && have_last) chk("frame_spacing", cyc - last_cyc, GAP + 2);
        end
      end
      chk("beat_grant", grant, 32'(1) << cur_src);
      if ((cur_src == 0 ? exp0_q.size() : exp1_q.size()) == 0) begin
        fail_now("unexpected_beat");
      end else begin
        e = (cur_src == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
        chk("beat_data", m_axis_tdata, e[7:0]);
        chk("beat_last", m_axis_tlast, e[8]);
      end
      if (m_axis_tlast) begin
        in_frame  = 1'b0;
        last_cyc  = cyc;
        have_last = 1'b1;
      end
    end
  end

  // Ready must only ever go to the granted source; grant is one-hot or zero.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("tready_owner", s_axis_tready & ~grant, 0);
      chk("grant_onehot0", $onehot0(grant), 1);
      if (trunc_err) trunc_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    src_valid = 2'b00;
    src_last  = 2'b00;
    src_data[0] = 8'h00;
    src_data[1] = 8'h00;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mlast", m_axis_tlast, 0);
    chk("rst_mdata", m_axis_tdata, 0);
    chk("rst_trunc", trunc_err, 0);
    chk("rst_err_src", err_src, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single 16-byte frame from source 0, then the forced gap.
    order_q.push_back(0);
    fork
      send_frame(0, 16, 0, 1'b0);
      begin
        @(negedge clk);
        chk("grant_before", grant, 0);
        @(negedge clk);
        chk("grant_1clk", grant, 2'b01);
        chk("busy_xfer", busy, 1);
      end
    join
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk);
      chk("gap_hold", {busy, s_axis_tready}, 3'b100);
    end
    @(negedge clk);
    chk("gap_end_idle", busy, 0);

    // Both sources back-to-back, two 12-byte frames each.
    have_last  = 1'b0;
    gap_chk_en = 1'b1;
`ifdef TX_ARB_PRIO_EN
    order_q.push_back(0); order_q.push_back(0); order_q.push_back(1); order_q.push_back(1);
`else
    order_q.push_back(1); order_q.push_back(0); order_q.push_back(1); order_q.push_back(0);
`endif
    fork
      begin send_frame(0, 12, 1, 1'b0); send_frame(0, 12, 2, 1'b0); end
      begin send_frame(1, 12, 1, 1'b0); send_frame(1, 12, 2, 1'b0); end
    join
    wait_idle();
    gap_chk_en = 1'b0;

    // Runaway frame from source 1 is cut at MAXB; then an exactly-MAXB frame is not.
    order_q.push_back(1);
    send_frame(1, MAXB + 4, 3, 1'b0);
    wait_idle();
    chk("trunc_pulses", trunc_cnt, 1);
    chk("trunc_err_src", err_src, 1);
    order_q.push_back(0);
    send_frame(0, MAXB, 3, 1'b0);
    wait_idle();
    chk("exact_max_no_trunc", trunc_cnt, 1);
    chk("err_src_held", err_src, 1);

    // Random backpressure and valid bubbles with both sources competing.
    rnd_en = 1'b1;
`ifdef TX_ARB_PRIO_EN
    order_q.push_back(0); order_q.push_back(1);
`else
    order_q.push_back(1); order_q.push_back(0);
`endif
    fork
      send_frame(0, 20, 4, 1'b1);
      send_frame(1, 8, 4, 1'b1);
    join
    wait_idle();
    rnd_en = 1'b0;
    chk("q0_empty", exp0_q.size(), 0);
    chk("q1_empty", exp1_q.size(), 0);
    chk("order_empty", order_q.size(), 0);

    // Reset in the middle of a frame, both sources requesting.
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    src_data[0] = 8'hA5;
    src_data[1] = 8'h5A;
    src_last    = 2'b00;
    src_valid   = 2'b11;
    n = 0;
    @(negedge clk);
    while (grant == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_granted", (grant != 2'b00), 1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_mvalid", m_axis_tvalid, 0);
    chk("mid_rst_mlast", m_axis_tlast, 0);
    chk("mid_rst_mdata", m_axis_tdata, 0);
    chk("mid_rst_err_src", err_src, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_src0_first", grant, 2'b01);
    chk("post_rst_data", m_axis_tdata, 8'hA5);
    @(posedge clk);
    #1 src_last[0] = 1'b1;
    @(posedge clk);
    #1;
    src_valid[0] = 1'b0;
    src_last[0]  = 1'b0;
    n = 0;
    @(negedge clk);
    while (grant != 2'b10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_src1_next", grant, 2'b10);
    @(posedge clk);
    #1 src_last[1] = 1'b1;
    @(posedge clk);
    #1;
    src_valid[1] = 1'b0;
    src_last[1]  = 1'b0;
    wait_idle();
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
